// File: rtl/usb2_in_arbiter_pkg.sv
// Shared types and defaults for the USB2 buffer-port arbiters.
// The IN-side arbiter and the future OUT-side arbiter both import this package.
package usb2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    COMMIT  = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  localparam int ARB_ADDR_W      = 9;
  localparam int ARB_LEN_W       = 10;
  localparam int ARB_ACK_TIMEOUT = 4096;

endpackage

// File: rtl/usb2_in_arbiter_if.sv
// Connection to the core's external IN-endpoint buffer port (buf_in_* on usb2_top).
// The master modport is the arbiter side; the slave modport is the core side.
interface usb2_buf_in_if
  import usb2_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int LEN_W  = ARB_LEN_W
) ();

  // Handshake: buf_in_wren qualifies buf_in_addr/buf_in_data for one byte write.
  // buf_in_commit is held high with a stable buf_in_commit_len until the master
  // samples buf_in_commit_ack high. buf_in_ready is a level from the core.
  logic [ADDR_W-1:0] buf_in_addr;
  logic [7:0]        buf_in_data;
  logic              buf_in_wren;
  logic              buf_in_ready;
  logic              buf_in_commit;
  logic [LEN_W-1:0]  buf_in_commit_len;
  logic              buf_in_commit_ack;

  modport master (
    output buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len,
    input  buf_in_ready, buf_in_commit_ack
  );

  modport slave (
    input  buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len,
    output buf_in_ready, buf_in_commit_ack
  );

endinterface

// File: rtl/usb2_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above rr_ptr,
// wrapping from N-1 back to 0.
module usb2_rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N-1:0]     win_oh,
  output logic [PTR_W-1:0] win_idx,
  output logic             any
);

  int c;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    c       = 0;
    for (int k = 0; k < N; k++) begin
      c = int'(rr_ptr) + k;
      if (c >= N) c = c - N;
      if (!any && req[c]) begin
        any        = 1'b1;
        win_idx    = PTR_W'(c);
        win_oh[c]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb2_in_arbiter.sv
// Round-robin owner of the core's IN buffer port: one requester per packet
// (fill then commit), with a commit watchdog so a lost ack cannot lock the port.
module usb2_in_arbiter
  import usb2_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = ARB_ADDR_W,
  parameter int LEN_W       = ARB_LEN_W,
  parameter int ACK_TIMEOUT = ARB_ACK_TIMEOUT
) (
  input  logic                      ext_clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]      req_data,
  input  logic [NUM_REQ-1:0]        req_wren,
  input  logic [NUM_REQ-1:0]        req_commit,
  input  logic [NUM_REQ*LEN_W-1:0]  req_commit_len,
  output logic [NUM_REQ-1:0]        req_done,
  output logic                      req_ready,
  usb2_buf_in_if.master             core,
  output logic                      err_commit_timeout,
  output logic                      busy,
  output arb_state_t                dbg_state
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(ACK_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(ACK_TIMEOUT - 1);

  arb_state_t         state, state_n;
  logic [NUM_REQ-1:0] gnt_n, done_n, pick_oh;
  logic [PTR_W-1:0]   gidx, gidx_n, rr_ptr, rr_n, pick_idx;
  logic               pick_any;
  logic               commit_q, commit_n;
  logic [LEN_W-1:0]   len_q, len_n;
  logic [WD_W-1:0]    wd, wd_n;
  logic               err_n, busy_n;

  usb2_rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  always_ff @(posedge ext_clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      gnt                <= '0;
      gidx               <= '0;
      rr_ptr             <= '0;
      commit_q           <= 1'b0;
      len_q              <= '0;
      wd                 <= '0;
      req_done           <= '0;
      err_commit_timeout <= 1'b0;
      busy               <= 1'b0;
    end else begin
      state              <= state_n;
      gnt                <= gnt_n;
      gidx               <= gidx_n;
      rr_ptr             <= rr_n;
      commit_q           <= commit_n;
      len_q              <= len_n;
      wd                 <= wd_n;
      req_done           <= done_n;
      err_commit_timeout <= err_n;
      busy               <= busy_n;
    end
  end

  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    gidx_n   = gidx;
    rr_n     = rr_ptr;
    commit_n = commit_q;
    len_n    = len_q;
    wd_n     = wd;
    done_n   = '0;
    err_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          state_n = FILL;
          gnt_n   = pick_oh;
          gidx_n  = pick_idx;
          rr_n    = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end
      end
      FILL: begin
        // A commit in the same cycle as the request dropping still completes the packet.
        if (req_commit[gidx]) begin
          state_n  = COMMIT;
          commit_n = 1'b1;
          len_n    = req_commit_len[int'(gidx)*LEN_W +: LEN_W];
          wd_n     = '0;
        end else if (!req[gidx]) begin
          state_n = RELEASE;
          gnt_n   = '0;
        end
      end
      COMMIT: begin
        if (core.buf_in_commit_ack) begin
          state_n  = RELEASE;
          commit_n = 1'b0;
          gnt_n    = '0;
          done_n   = gnt;
        end else if (wd == WD_LAST) begin
          state_n  = RELEASE;
          commit_n = 1'b0;
          gnt_n    = '0;
          err_n    = 1'b1;
        end else begin
          wd_n = wd + 1'b1;
        end
      end
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  // Write path is a pure mux off the registered grant, so it adds no latency.
  always_comb begin
    core.buf_in_addr = '0;
    core.buf_in_data = '0;
    core.buf_in_wren = 1'b0;
    if (gnt != '0) begin
      core.buf_in_addr = req_addr[int'(gidx)*ADDR_W +: ADDR_W];
      core.buf_in_data = req_data[int'(gidx)*8 +: 8];
      core.buf_in_wren = (state == FILL) && req_wren[gidx];
    end
  end

  assign core.buf_in_commit     = commit_q;
  assign core.buf_in_commit_len = len_q;
  assign req_ready              = core.buf_in_ready & (|gnt);
  assign dbg_state              = state;

endmodule

// File: tb/tb_usb2_in_arbiter.sv
// Randomized scoreboard bench for usb2_in_arbiter: expected grant/commit/done/error
// events are queued by the drivers and popped by an independent monitor.
module tb_usb2_in_arbiter;
  import usb2_arb_pkg::*;

  localparam int NUM_REQ     = 4;
  localparam int ADDR_W      = 9;
  localparam int LEN_W       = 10;
  localparam int ACK_TIMEOUT = 16;
  localparam int EW          = 16;
  localparam logic [1:0] K_GNT = 2'd0, K_COMMIT = 2'd1, K_DONE = 2'd2, K_ERR = 2'd3;

  // ---------------- clock / reset ----------------
  logic ext_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 ext_clk = ~ext_clk;

  logic [NUM_REQ-1:0]        req = '0, req_wren = '0, req_commit = '0;
  logic [NUM_REQ-1:0]        gnt, req_done;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ*8-1:0]      req_data = '0;
  logic [NUM_REQ*LEN_W-1:0]  req_commit_len = '0;
  logic                      req_ready, err_commit_timeout, busy;
  arb_state_t                dbg_state;

  usb2_buf_in_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) core ();

  usb2_in_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .ext_clk            (ext_clk),
    .reset_n            (reset_n),
    .req                (req),
    .gnt                (gnt),
    .req_addr           (req_addr),
    .req_data           (req_data),
    .req_wren           (req_wren),
    .req_commit         (req_commit),
    .req_commit_len     (req_commit_len),
    .req_done           (req_done),
    .req_ready          (req_ready),
    .core               (core.master),
    .err_commit_timeout (err_commit_timeout),
    .busy               (busy),
    .dbg_state          (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];
  int  grant_log[$];
  int  model_ptr = 0;
  bit  mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] ev(input logic [1:0] k, input int idx, input logic [LEN_W-1:0] len);
    logic [2:0] i3;
    i3 = 3'(idx);
    return {k, i3, 1'b0, len};
  endfunction

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return 7;
  endfunction

  // Reference arbitration: first requester at or after the pointer, with wrap.
  function automatic int model_pick(input logic [NUM_REQ-1:0] r);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r[(model_ptr + k) % NUM_REQ]) return (model_ptr + k) % NUM_REQ;
    end
    return 0;
  endfunction

  task automatic observe(input logic [EW-1:0] got);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got %0h expected none", got);
    end else begin
      e = exp_q.pop_front();
      check("event", got, e);
    end
  endtask

  // ---------------- monitor ----------------
  logic [NUM_REQ-1:0] prev_gnt = '0;
  logic               prev_commit = 1'b0;

  always @(negedge ext_clk) begin
    if (!mon_en) begin
      prev_gnt    = '0;
      prev_commit = 1'b0;
    end else begin
      if (gnt != '0 && prev_gnt == '0) begin
        check("gnt_onehot", 64'($onehot(gnt)), 64'd1);
        grant_log.push_back(onehot_idx(gnt));
        observe(ev(K_GNT, onehot_idx(gnt), '0));
      end
      if (core.buf_in_commit && !prev_commit)
        observe(ev(K_COMMIT, onehot_idx(gnt), core.buf_in_commit_len));
      if (req_done != '0) begin
        check("done_onehot", 64'($onehot(req_done)), 64'd1);
        observe(ev(K_DONE, onehot_idx(req_done), '0));
      end
      if (err_commit_timeout) observe(ev(K_ERR, 0, '0));
      prev_gnt    = gnt;
      prev_commit = core.buf_in_commit;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic grant_phase(input int lat, output int w);
    int cnt;
    w         = model_pick(req);
    model_ptr = (w + 1) % NUM_REQ;
    exp_q.push_back(ev(K_GNT, w, '0));
    cnt = 0;
    while (gnt == '0 && cnt < 12) begin
      @(negedge ext_clk);
      cnt++;
    end
    check("grant_latency", 64'(cnt), 64'(lat));
    check("grant_value", 64'(gnt), 64'(1) << w);
  endtask

  // Called at a negedge with req already set; returns at the RELEASE negedge.
  task automatic run_round(input int lat, input int nwr, input bit abort,
                           input logic [LEN_W-1:0] len, input int ack_d, output int w);
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
    logic              we;
    int                cnt;
    grant_phase(lat, w);
    for (int i = 0; i < nwr; i++) begin
      a  = ADDR_W'(i);
      d  = 8'($urandom);
      we = ($urandom_range(0, 3) != 0);
      req_wren    = NUM_REQ'($urandom);
      req_wren[w] = we;
      req_commit  = ($urandom_range(0, 1) == 0) ? NUM_REQ'($urandom) : '0;
      req_commit[w] = 1'b0;
      req_addr = (NUM_REQ*ADDR_W)'({$urandom(), $urandom()});
      req_data = (NUM_REQ*8)'($urandom());
      req_addr[w*ADDR_W +: ADDR_W] = a;
      req_data[w*8 +: 8] = d;
      core.buf_in_ready = 1'($urandom);
      #1;
      check("fill_mux", {req_ready, core.buf_in_wren, core.buf_in_addr, core.buf_in_data},
            {core.buf_in_ready, we, a, d});
      @(negedge ext_clk);
    end
    req_wren   = '0;
    req_commit = '0;
    if (abort) begin
      req[w] = 1'b0;
      @(negedge ext_clk);
      check("abort_release", {gnt, core.buf_in_commit, busy}, {4'b0000, 1'b0, 1'b1});
    end else begin
      req_commit_len = (NUM_REQ*LEN_W)'({$urandom(), $urandom()});
      req_commit_len[w*LEN_W +: LEN_W] = len;
      req_commit[w] = 1'b1;
      exp_q.push_back(ev(K_COMMIT, w, len));
      exp_q.push_back((ack_d != 0) ? ev(K_DONE, w, '0) : ev(K_ERR, 0, '0));
      @(negedge ext_clk);
      req_commit = '0;
      req_wren   = '1;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
        if (!core.buf_in_commit) break;
        cnt++;
        #1;
        check("commit_hold", {core.buf_in_commit_len, core.buf_in_wren, gnt},
              {len, 1'b0, NUM_REQ'(1 << w)});
        if (ack_d != 0 && cnt == ack_d) core.buf_in_commit_ack = 1'b1;
        @(negedge ext_clk);
        core.buf_in_commit_ack = 1'b0;
      end
      req_wren = '0;
      check("commit_cycles", 64'(cnt), 64'((ack_d != 0) ? ack_d : ACK_TIMEOUT));
      check("release", {gnt, core.buf_in_commit, busy}, {4'b0000, 1'b0, 1'b1});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int ack_d;
    bit abort;
    logic [LEN_W-1:0] len;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    core.buf_in_ready      = 1'b0;
    core.buf_in_commit_ack = 1'b0;

    repeat (3) @(negedge ext_clk);
    #1;
    check("reset_outputs", {gnt, req_done, core.buf_in_commit, core.buf_in_commit_len, core.buf_in_wren,
                            core.buf_in_addr, core.buf_in_data, err_commit_timeout, busy, req_ready}, 64'd0);
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    @(negedge ext_clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(negedge ext_clk);

    // Lone requester 2: 64 writes, len 64, ack after 5 commit cycles.
    req = 4'b0100;
    run_round(1, 64, 1'b0, 10'd64, 5, w);
    req = 4'b0010;
    // Requester 1 owns the port while others drive noise writes and commits.
    run_round(2, 12, 1'b0, LEN_W'($urandom), 3, w);
    req = 4'b1001;
    // Requester 3 aborts; requester 0 is pending and follows.
    run_round(2, 3, 1'b1, '0, 0, w);
    // No ack: watchdog must fire.
    run_round(2, 2, 1'b0, LEN_W'($urandom), 0, w);
    req = NUM_REQ'($urandom_range(1, 15));

    for (int r = 0; r < 30; r++) begin
      abort = ($urandom_range(0, 5) == 0);
      ack_d = ($urandom_range(0, 3) == 0) ? 0 : ($urandom_range(0, 4) == 0 ? 16 : int'($urandom_range(1, 16)));
      run_round(2, int'($urandom_range(0, 10)), abort, LEN_W'($urandom), ack_d, w);
      if (abort || $urandom_range(0, 1) == 0) req[w] = 1'b0;
      if ($urandom_range(0, 2) == 0) req = req | NUM_REQ'($urandom);
      if (req == '0) req[$urandom_range(0, NUM_REQ-1)] = 1'b1;
    end

    // Asynchronous reset in the middle of a commit.
    grant_phase(2, w);
    req_commit_len[w*LEN_W +: LEN_W] = 10'h155;
    req_commit[w] = 1'b1;
    exp_q.push_back(ev(K_COMMIT, w, 10'h155));
    @(negedge ext_clk);
    req_commit = '0;
    @(negedge ext_clk);
    check("pre_reset_commit", 64'(core.buf_in_commit), 64'd1);
    mon_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {gnt, req_done, core.buf_in_commit, core.buf_in_commit_len, core.buf_in_wren,
                                  core.buf_in_addr, core.buf_in_data, err_commit_timeout, busy, req_ready}, 64'd0);
    check("async_reset_state", 64'(dbg_state), 64'(IDLE));
    exp_q.delete();
    req = '1;
    @(negedge ext_clk);
    reset_n   = 1'b1;
    mon_en    = 1'b1;
    model_ptr = 0;
    grant_log.delete();

    // Four-way contention, immediate commits, one-cycle ack.
    for (int r = 0; r < 5; r++) begin
      run_round((r == 0) ? 1 : 2, 0, 1'b0, LEN_W'(r + 1), 1, w);
    end
    req = '0;
    repeat (4) @(negedge ext_clk);
    check("grant_order_len", 64'(grant_log.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < grant_log.size()) check("grant_order", 64'(grant_log[i]), 64'(exp_order[i]));
    end
    check("final_idle", {64'(dbg_state), 1'b0, busy}, {64'(IDLE), 1'b0, 1'b0});
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb2_in_arbiter.md
# usb2_in_arbiter

Shares the single external IN-endpoint buffer port of the USB 2.0 core (`buf_in_*` on `usb2_top`) among `NUM_REQ` independent producers in the `ext_clk` domain. It grants one requester at a time for a whole packet (fill, then commit), waits for the core's commit acknowledge and then moves on in round-robin order. A commit watchdog keeps the port from locking if the acknowledge never arrives.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `ADDR_W`, 9: buffer address width.
- `LEN_W`, 10: commit length width.
- `ACK_TIMEOUT`, 4096: `ext_clk` cycles to wait for `buf_in_commit_ack` before abandoning a commit.

Ports:
- `ext_clk` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in NUM_REQ: level request per requester; held high until release.
- `gnt` out NUM_REQ: one-hot grant, registered.
- `req_addr` in NUM_REQ×ADDR_W: flattened per-requester write address; requester i occupies slice i.
- `req_data` in NUM_REQ×8: flattened write data.
- `req_wren` in NUM_REQ: write enable.
- `req_commit` in NUM_REQ: one-cycle commit pulse.
- `req_commit_len` in NUM_REQ×LEN_W: packet length, valid with `req_commit`.
- `req_done` out NUM_REQ: one-cycle pulse to the granted requester when its commit is acknowledged.
- `req_ready` out 1: `buf_in_ready`, gated by the presence of any grant.
- `buf_in_addr` out ADDR_W: to core.
- `buf_in_data` out 8: to core.
- `buf_in_wren` out 1: to core.
- `buf_in_ready` in 1: from core.
- `buf_in_commit` out 1: to core.
- `buf_in_commit_len` out LEN_W: to core.
- `buf_in_commit_ack` in 1: from core.
- `err_commit_timeout` out 1: one-cycle pulse when the watchdog fires.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: no grant; pick a requester.
  - FILL: requester owns the port and writes its packet.
  - COMMIT: commit forwarded to the core; waiting for acknowledge.
  - RELEASE: one-cycle turnaround; grant dropped.
- IDLE → FILL:
  - Taken when any `req` is high.
  - Winner is the first asserted `req` at or after `rr_ptr`, searching upward with wrap (NUM_REQ−1 → 0).
  - `gnt` is set to the winner; `rr_ptr` is set to winner+1 mod NUM_REQ.
- FILL:
  - `buf_in_addr`, `buf_in_data` and `buf_in_wren` are a combinational mux of the granted slice.
  - Wren from non-granted requesters is ignored.
  - `req_ready` = `buf_in_ready` & (`gnt` ≠ 0).
- FILL → COMMIT: on `req_commit` from the granted requester.
  - Latch its `req_commit_len` into `buf_in_commit_len`.
  - Assert `buf_in_commit` from the next cycle.
  - Clear the watchdog.
  - Commit pulses from non-granted requesters are ignored.
- FILL → RELEASE (abort):
  - Taken if the granted `req` drops before committing.
  - No commit is issued; buffer contents are abandoned.
- COMMIT:
  - `buf_in_commit` is held high.
  - `buf_in_wren` is forced to 0.
  - The watchdog increments each cycle.
- COMMIT → RELEASE on `buf_in_commit_ack` = 1:
  - Deassert commit.
  - Pulse `req_done` for the granted requester.
- COMMIT → RELEASE on watchdog = ACK_TIMEOUT−1 with no ack:
  - Deassert commit.
  - Pulse `err_commit_timeout`.
  - No `req_done`.
- If ack and timeout occur in the same cycle, the ack wins: `req_done` pulses, no error.
- RELEASE: `gnt` = 0 for one cycle, then → IDLE.
- A requester that holds `req` through RELEASE competes normally on the next arbitration, behind the others due to `rr_ptr`.
- Asynchronous reset, including mid-operation:
  - State = IDLE; `rr_ptr` = 0.
  - All outputs are 0: `gnt`, `req_done`, `buf_in_*`, `err_commit_timeout`, `busy`.
  - Mux outputs are 0 with no grant.
- Watchdog width is clog2(ACK_TIMEOUT); it saturates and never wraps.

## Timing
- Request-to-grant latency: `req` sampled high in IDLE at cycle N → `gnt` high at N+1.
- Commit latency: `req_commit` at cycle T → `buf_in_commit` and `buf_in_commit_len` valid at T+1, held until ack is sampled.
- Ack sampled at cycle A:
  - `buf_in_commit` = 0 and `req_done` = 1 at A+1 (RELEASE, `gnt` = 0).
  - IDLE at A+2.
  - Next `gnt` earliest at A+3.
- The write path adds no latency: mux is combinational from the registered `gnt`.
- `gnt`, `busy`, `buf_in_commit`, `buf_in_commit_len`, `req_done` and `err_commit_timeout` are all registered.

## Structure
- Package `usb2_arb_pkg` holds:
  - the state enum (IDLE, FILL, COMMIT, RELEASE);
  - default width constants ADDR_W=9, LEN_W=10;
  - the `ACK_TIMEOUT` default.
- One sub-module, `usb2_rr_pick`:
  - Inputs: `req` vector, `rr_ptr`.
  - Outputs: one-hot winner, winner index, `any`.
  - Purely combinational; reused by future OUT-side arbiter.
- Top module holds the FSM, `rr_ptr`, watchdog, length latch and datapath mux.

## Test plan
- Single requester 2 writes addr 0..63, commits len=64, ack after 5 cycles:
  - `gnt`=0100 one cycle after `req`;
  - `buf_in_commit_len`=64 held 5 cycles;
  - `req_done[2]` pulses once; next grant ≥3 cycles after ack.
- All four `req` high continuously, each commits immediately, ack after 1 cycle → grant order 0,1,2,3,0; no requester is granted twice in a row.
- Requester 1 granted while requester 3 drives `req_wren` and `req_commit` → `buf_in_wren` reflects only requester 1; no commit from 3.
- Ack never arrives, ACK_TIMEOUT=16:
  - `buf_in_commit` high exactly 16 cycles;
  - `err_commit_timeout` pulses once; no `req_done`; returns to IDLE.
- Granted requester drops `req` mid-FILL → no `buf_in_commit`, `gnt`=0 next cycle, other pending requester granted 2 cycles later.
- Assert `reset_n`=0 during COMMIT → all outputs 0 immediately (async); after release, `rr_ptr`=0 so requester 0 wins a 4-way tie.
